// File: rtl/load_split_sequencer.sv
// Load sequencer: issues one or two aligned word reads per load, merges the
// words and extracts/extends the byte, halfword or word result. Word-crossing
// loads to IO space, and illegal funct3 codes, get an error response with no
// memory access so IO side-effects never repeat.
module load_split_sequencer #(
  parameter bit         ALLOW_SPLIT = 1'b1,
  parameter logic [3:0] IO_REGION   = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q, w0_q, w1_q, resp_data_q;
  logic [2:0]  f3_q;
  logic        split_q, resp_err_q;

  logic        legal, split_now, err_now, accept;
  logic [31:0] word0, m_w0, m_w1, shifted, merged;

  // Request decode: legality, word-crossing and rejection at accept time
  always_comb begin
    legal     = (req_funct3 == F_LB) || (req_funct3 == F_LH) || (req_funct3 == F_LW) ||
                (req_funct3 == F_LBU) || (req_funct3 == F_LHU);
    split_now = ((req_funct3 == F_LW) && (req_addr[1:0] != 2'b00)) ||
                (((req_funct3 == F_LH) || (req_funct3 == F_LHU)) && (req_addr[1:0] == 2'b11));
    err_now   = !legal || (split_now && (!ALLOW_SPLIT || (req_addr[31:28] == IO_REGION)));
  end

  // Handshake and status; gated by reset so nothing leaks while it is held
  assign req_ready  = (state == IDLE) && rst;
  assign accept     = req_ready && req_valid;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign word0      = {addr_q[31:2], 2'b00};

  // Read strobe: first word in the accept cycle, second word from WAIT0
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = 32'h0;
    if (accept && !err_now) begin
      mem_en   = 1'b1;
      mem_addr = {req_addr[31:2], 2'b00};
    end else if ((state == WAIT0) && split_q) begin
      mem_en   = 1'b1;
      mem_addr = word0 + 32'd4;
    end
  end

  // Merge: the word arriving this cycle is taken straight from mem_rdata
  always_comb begin
    m_w0    = (state == WAIT0) ? mem_rdata : w0_q;
    m_w1    = (state == WAIT1) ? mem_rdata : 32'h0;
    shifted = 32'({m_w1, m_w0} >> {addr_q[1:0], 3'b000});
    case (f3_q)
      F_LB:    merged = {{24{shifted[7]}}, shifted[7:0]};
      F_LBU:   merged = {24'h0, shifted[7:0]};
      F_LH:    merged = {{16{shifted[15]}}, shifted[15:0]};
      F_LHU:   merged = {16'h0, shifted[15:0]};
      F_LW:    merged = shifted;
      default: merged = 32'h0;
    endcase
  end

  // Sequencer FSM with registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= 32'h0;
      f3_q        <= 3'b000;
      split_q     <= 1'b0;
      w0_q        <= 32'h0;
      w1_q        <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= req_addr;
          f3_q    <= req_funct3;
          split_q <= split_now;
          w0_q    <= 32'h0;
          w1_q    <= 32'h0;
          if (err_now) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= 32'h0;
            state       <= RESP;
          end else begin
            state <= WAIT0;
          end
        end
        WAIT0: begin
          w0_q <= mem_rdata;
          if (split_q) begin
            state <= WAIT1;
          end else begin
            resp_data_q <= merged;
            resp_err_q  <= 1'b0;
            state       <= RESP;
          end
        end
        WAIT1: begin
          w1_q        <= mem_rdata;
          resp_data_q <= merged;
          resp_err_q  <= 1'b0;
          state       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_data_q <= 32'h0;
          resp_err_q  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_split_sequencer.sv
// Bench for load_split_sequencer: directed loads against a small memory model;
// expected reads and responses go into queues, monitors pop and compare.
module tb_load_split_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_en, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, mem_addr, mem_rdata, resp_data;
  logic [2:0]  req_funct3;

  // second instance with splitting disabled
  logic        b_req_valid, b_req_ready, b_mem_en, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_req_addr, b_mem_addr, b_resp_data;
  logic [31:0] b_mem_rdata = 32'h44332211;
  logic [2:0]  b_req_funct3;
  logic        b_resp_ready = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  bit          seen = 1'b0;

  load_split_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err), .busy(busy));

  load_split_sequencer #(.ALLOW_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_funct3(b_req_funct3), .mem_en(b_mem_en),
    .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_err(b_resp_err), .busy(b_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h10000000: return 32'h44332211;
      32'h10000004: return 32'h88776655;
      32'hFFFFFFFC: return 32'hAABBCCDD;
      32'h00000000: return 32'h11223344;
      default:      return 32'h0;
    endcase
  endfunction

  // synchronous-read memory model
  always @(posedge clk) if (mem_en) mem_rdata <= mem_rd(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // read monitor
  always @(negedge clk) begin
    if (mem_en) begin
      if (rd_q.size() == 0) chk("unexpected_read", mem_addr, 32'hxxxxxxxx);
      else chk("read_addr", mem_addr, rd_q.pop_front());
    end else if (rst) begin
      chk("mem_addr_idle", mem_addr, 32'h0);
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          seen = 1'b1;
        end
        chk("resp_data", resp_data, exp_q[0].data);
        chk("resp_err", {31'h0, resp_err}, {31'h0, exp_q[0].err});
        chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                      input logic e, input int lat, input int nrd, input bit want_resp);
    exp_t x;
    bit   ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("req_ready_timeout", 32'h0, 32'h1);
    req_addr = a; req_funct3 = f3; req_valid = 1'b1;
    if (nrd > 0) rd_q.push_back({a[31:2], 2'b00});
    if (nrd > 1) rd_q.push_back({a[31:2], 2'b00} + 32'd4);
    x.data = d; x.err = e; x.lat = lat; x.acc = cyc;
    if (want_resp) exp_q.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  task automatic run(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                     input logic e, input int lat, input int nrd);
    send(a, f3, d, e, lat, nrd, 1'b1);
    wait_done();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_funct3 = 3'b0; resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_addr = 32'h0; b_req_funct3 = 3'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'h0, resp_err}, 32'h0);
    chk("rst_resp_data",  resp_data, 32'h0);
    chk("rst_mem_en",     {31'h0, mem_en}, 32'h0);
    chk("rst_busy",       {31'h0, busy}, 32'h0);
    @(negedge clk); rst = 1'b1;

    // aligned and split loads
    run(32'h10000000, 3'b010, 32'h44332211, 1'b0, 2, 1);
    run(32'h10000001, 3'b010, 32'h55443322, 1'b0, 3, 2);
    run(32'h10000003, 3'b010, 32'h77665544, 1'b0, 3, 2);
    run(32'h10000006, 3'b001, 32'hFFFF8877, 1'b0, 2, 1);
    run(32'h10000006, 3'b101, 32'h00008877, 1'b0, 2, 1);
    run(32'h10000003, 3'b000, 32'h00000044, 1'b0, 2, 1);
    run(32'h10000003, 3'b001, 32'h00005544, 1'b0, 3, 2);
    run(32'h10000001, 3'b001, 32'h00003322, 1'b0, 2, 1);
    run(32'h10000007, 3'b000, 32'hFFFFFF88, 1'b0, 2, 1);
    run(32'h10000007, 3'b100, 32'h00000088, 1'b0, 2, 1);
    // errors: IO split, illegal funct3
    run(32'h80000022, 3'b010, 32'h0, 1'b1, 1, 0);
    run(32'h10000000, 3'b011, 32'h0, 1'b1, 1, 0);
    run(32'h8000000F, 3'b111, 32'h0, 1'b1, 1, 0);
    // address wrap on the second read
    run(32'hFFFFFFFE, 3'b010, 32'h3344AABB, 1'b0, 3, 2);

    // backpressure: hold response for 3 cycles
    resp_ready = 1'b0;
    send(32'h10000001, 3'b010, 32'h55443322, 1'b0, 3, 2, 1'b1);
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_done();

    // reset during WAIT1: reads already issued, no response
    send(32'h10000001, 3'b010, 32'h0, 1'b0, 3, 2, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst_mem_en",     {31'h0, mem_en}, 32'h0);
    chk("midrst_mem_addr",   mem_addr, 32'h0);
    chk("midrst_busy",       {31'h0, busy}, 32'h0);
    chk("midrst_req_ready",  {31'h0, req_ready}, 32'h0);
    chk("midrst_resp_data",  resp_data, 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    run(32'h10000000, 3'b010, 32'h44332211, 1'b0, 2, 1);

    // splitting disabled instance
    @(posedge clk); #1;
    b_req_addr = 32'h10000002; b_req_funct3 = 3'b010; b_req_valid = 1'b1; #1;
    chk("ns_no_read", {31'h0, b_mem_en}, 32'h0);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("ns_err_valid", {31'h0, b_resp_valid}, 32'h1);
    chk("ns_err",       {31'h0, b_resp_err}, 32'h1);
    chk("ns_err_data",  b_resp_data, 32'h0);
    @(posedge clk); #1;
    b_req_addr = 32'h10000000; b_req_funct3 = 3'b010; b_req_valid = 1'b1; #1;
    chk("ns_aligned_read", b_mem_en ? b_mem_addr : 32'hDEAD0000, 32'h10000000);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("ns_aligned_valid", {31'h0, b_resp_valid}, 32'h1);
    chk("ns_aligned_data",  b_resp_data, 32'h44332211);

    repeat (3) @(posedge clk); #1;
    chk("reads_drained", rd_q.size(), 32'h0);
    chk("resps_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_split_sequencer.md
Name: load_split_sequencer

Overview:
Sits between the pipeline's load path and the synchronous-read data memory port. It runs each load as one or two aligned word reads, and uses two reads when a misaligned LW/LH/LHU crosses a word boundary. It then merges the two words and extracts and sign- or zero-extends the byte, halfword or word result. Misaligned loads to the IO region and unsupported funct3 values are rejected with an error response, so IO side-effects such as FIFO pops never happen twice.

Parameters:
ALLOW_SPLIT, 1, 1: word-crossing loads use two reads; 0: every word-crossing load returns an error without accessing memory.
IO_REGION, 4'h8, value of addr[31:28] that marks non-splittable IO space.

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset; asynchronous assert, active-low
req_valid  in  1  load request present
req_ready  out  1  high only in IDLE
req_addr  in  32  byte address
req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
mem_en  out  1  read strobe to memory
mem_addr  out  32  word-aligned read address; 0 when mem_en low
mem_rdata  in  32  read data, valid the cycle after mem_en
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
resp_data  out  32  extended load result; 0 on error
resp_err  out  1  request rejected
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WAIT0, WAIT1, RESP. Reset forces IDLE immediately.
- Values in reset: resp_valid=0, resp_err=0, resp_data=0, mem_en=0, mem_addr=0, busy=0; captured words and latched request cleared.
- Accept: handshake when req_valid && req_ready in IDLE. addr and funct3 are latched.
- Error check at accept. The request is an error if:
  - funct3 is not one of the five legal codes; or
  - the load is a split and (ALLOW_SPLIT==0 or addr[31:28]==IO_REGION).
  On error: no mem_en; next state RESP with resp_err=1 and resp_data=0 (response in cycle +1).
- Split condition: (LW and addr[1:0]!=0) or (LH/LHU and addr[1:0]==3). Byte loads never split.
- Non-error accept (cycle 0):
  - mem_en=1 combinationally in the same cycle, mem_addr={addr[31:2],2'b00}.
  - Next state WAIT0.
- WAIT0 (cycle 1):
  - Capture mem_rdata as w0.
  - If split: mem_en=1, mem_addr=word0+4 (32-bit wrap, so 0xFFFFFFFC+4=0x00000000); next state WAIT1.
  - Else: next state RESP.
- WAIT1 (cycle 2): capture mem_rdata as w1; next state RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err are registered and held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency from accept to first resp_valid: aligned 2 cycles, split 3 cycles, error 1 cycle.
- Merge:
  - Form the 64-bit value {w1,w0}, with w1=0 when there is no split.
  - Shift right by 8*addr[1:0] and take the low 8/16/32 bits.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- mem_en is never asserted in RESP or IDLE-without-accept. At most 2 reads per request.
- req_valid while busy is ignored (req_ready=0); the requester holds it.
- Reset mid-operation:
  - Any in-flight read data is discarded and no response is produced.
  - The first request after reset deassertion is accepted normally.

Test Plan:
Common setup: mem[0x10000000]=0x44332211, mem[0x10000004]=0x88776655; resp_ready=1 unless stated.
1. LW 0x10000000 -> one read of 0x10000000 in cycle 0; resp_valid in cycle 2 with resp_data=0x44332211, resp_err=0.
2. LW 0x10000001 -> reads 0x10000000 (cycle 0) and 0x10000004 (cycle 1); resp_data=0x55443322 in cycle 3.
3. LH 0x10000006 -> 0xFFFF8877; LHU 0x10000006 -> 0x00008877; LB 0x10000003 -> 0x00000044; LH 0x10000003 -> two reads, 0x00005544.
4. LW 0x80000022 -> no mem_en, resp_err=1, resp_data=0 in cycle 1; funct3=011 at any address -> same. With ALLOW_SPLIT=0, LW 0x10000002 -> error with no read.
5. LW 0xFFFFFFFE -> reads 0xFFFFFFFC then 0x00000000; merged result {w1[15:0], w0[31:16]}.
6. Backpressure and reset:
   - resp_ready low for 3 cycles in RESP -> resp_valid, resp_data and resp_err stable; req_ready=0; no mem_en.
   - rst low during WAIT1 -> all outputs 0 immediately; IDLE after release; no stale response.
